// File: rtl/cache_writeback_encoder.sv
// cache_writeback_encoder: streams an evicted dirty cache line to the memory write port.
// It rebuilds each word address as {tag, set, offset} and sends one word per
// valid/ready beat. The memory-side outputs are registered.
// Optional feature macro: CACHE_WB_DIRTY_MASK_EN. When it is defined, the block has
// an extra input, evict_dirty_mask, and sends only the words whose mask bit is set.
module cache_writeback_encoder #(
  parameter int unsigned TAG_WIDTH  = 13,
  parameter int unsigned SET_WIDTH  = 8,
  parameter int unsigned OFF_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned LINE_WORDS = 1 << OFF_WIDTH,
  localparam int unsigned LineW      = LINE_WORDS * DATA_WIDTH,
  localparam int unsigned AddrW      = TAG_WIDTH + SET_WIDTH + OFF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  evict_valid,
  output logic                  evict_ready,
  input  logic [TAG_WIDTH-1:0]  evict_tag,
  input  logic [SET_WIDTH-1:0]  evict_set,
  input  logic [LineW-1:0]      evict_data,
`ifdef CACHE_WB_DIRTY_MASK_EN
  input  logic [LINE_WORDS-1:0] evict_dirty_mask,
`endif
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [AddrW-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_last,
  output logic                  wb_done
);

  // The beat counter is kept at least 1 bit wide so that single-word lines still work.
  localparam int unsigned BeatW = (OFF_WIDTH > 0) ? OFF_WIDTH : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [SET_WIDTH-1:0]    set_q, set_d;
  logic [LineW-1:0]        line_q, line_d;
  logic [LINE_WORDS-1:0]   mask_q, mask_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [AddrW-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;

  logic [LINE_WORDS-1:0]   mask_in;
  logic                    accept;
  logic [BeatW:0]          first_hit, first_more, next_hit, next_more;

`ifdef CACHE_WB_DIRTY_MASK_EN
  assign mask_in = evict_dirty_mask;
`else
  assign mask_in = '1;
`endif

  // This function returns {found, index}. The index is the lowest dirty word at or above 'from'.
  function automatic logic [BeatW:0] find_dirty(input logic [LINE_WORDS-1:0] m, input int from);
    logic [BeatW:0] r;
    r = '0;
    for (int i = LINE_WORDS - 1; i >= 0; i--) begin
      if (i >= from && m[i]) r = {1'b1, BeatW'(i)};
    end
    return r;
  endfunction

  // The offset goes into its own field by concatenation. It never carries into the set field.
  function automatic logic [AddrW-1:0] make_addr(input logic [TAG_WIDTH-1:0] t,
                                                 input logic [SET_WIDTH-1:0] s,
                                                 input logic [BeatW-1:0]     b);
    logic [AddrW-1:0] a;
    a = AddrW'({t, s}) << OFF_WIDTH;
    a = a | AddrW'(b);
    return a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick_word(input logic [LineW-1:0] line,
                                                      input logic [BeatW-1:0] b);
    return line[int'(b) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign accept = evict_valid && evict_ready;

  // Dirty-word search: the first dirty word of a new request, and the next dirty word of the line being sent.
  always_comb begin
    first_hit  = find_dirty(mask_in, 0);
    first_more = find_dirty(mask_in, int'(first_hit[BeatW-1:0]) + 1);
    next_hit   = find_dirty(mask_q, int'(beat_q) + 1);
    next_more  = find_dirty(mask_q, int'(next_hit[BeatW-1:0]) + 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic. An all-clean line stays in IDLE and only pulses done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && first_hit[BeatW]) state_d = StSend;
      StSend: if (mem_ready && last_q)        state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic. Ready depends only on the state and on reset, never on evict_valid.
  always_comb begin
    evict_ready = (state_q == StIdle) && !rst;
    mem_valid   = valid_q;
    mem_addr    = addr_q;
    mem_data    = wdata_q;
    mem_last    = last_q;
    wb_done     = done_q;
  end

  // Datapath next values: capture the line at acceptance, then move to the next beat on each handshake.
  always_comb begin
    tag_d   = tag_q;
    set_d   = set_q;
    line_d  = line_q;
    mask_d  = mask_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tag_d  = evict_tag;
          set_d  = evict_set;
          line_d = evict_data;
          mask_d = mask_in;
          beat_d = first_hit[BeatW-1:0];
          if (first_hit[BeatW]) begin
            valid_d = 1'b1;
            last_d  = !first_more[BeatW];
            addr_d  = make_addr(evict_tag, evict_set, first_hit[BeatW-1:0]);
            wdata_d = pick_word(evict_data, first_hit[BeatW-1:0]);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (mem_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            beat_d  = next_hit[BeatW-1:0];
            last_d  = !next_more[BeatW];
            addr_d  = make_addr(tag_q, set_q, next_hit[BeatW-1:0]);
            wdata_d = pick_word(line_q, next_hit[BeatW-1:0]);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. Reset abandons any burst in progress without pulsing done.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      set_q   <= '0;
      line_q  <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      set_q   <= set_d;
      line_q  <= line_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cache_writeback_encoder.sv
// Directed self-checking bench for cache_writeback_encoder in its default configuration.
// The dirty-mask scenarios are included when CACHE_WB_DIRTY_MASK_EN is defined.
module tb_cache_writeback_encoder;

  localparam int TW = 13;
  localparam int SW = 8;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int AW = 23;

  logic              clk = 1'b0;
  logic              rst;
  logic              evict_valid;
  logic              evict_ready;
  logic [TW-1:0]     evict_tag;
  logic [SW-1:0]     evict_set;
  logic [LW*DW-1:0]  evict_data;
`ifdef CACHE_WB_DIRTY_MASK_EN
  logic [LW-1:0]     evict_dirty_mask;
`endif
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_last;
  logic              wb_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_writeback_encoder dut (
    .clk              (clk),
    .rst              (rst),
    .evict_valid      (evict_valid),
    .evict_ready      (evict_ready),
    .evict_tag        (evict_tag),
    .evict_set        (evict_set),
    .evict_data       (evict_data),
`ifdef CACHE_WB_DIRTY_MASK_EN
    .evict_dirty_mask (evict_dirty_mask),
`endif
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .mem_last         (mem_last),
    .wb_done          (wb_done)
  );

  // Advance one cycle. Sampling and driving both happen 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; evict_valid = 1'b0; mem_ready = 1'b0;
    evict_tag = '0; evict_set = '0; evict_data = '0;
`ifdef CACHE_WB_DIRTY_MASK_EN
    evict_dirty_mask = '1;
`endif
    tick; tick;
    checks++;
    if ({evict_ready, mem_valid, mem_last, wb_done, mem_addr, mem_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b l=%b d=%b a=%h dat=%h want all zero",
               evict_ready, mem_valid, mem_last, wb_done, mem_addr, mem_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (evict_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", evict_ready);
    end
  endtask

  task automatic test_single;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    ea = '{23'h6AF168, 23'h6AF169, 23'h6AF16A, 23'h6AF16B};
    ed = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    evict_tag = 13'h1ABC; evict_set = 8'h5A;
    evict_data = {ed[3], ed[2], ed[1], ed[0]};
    evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    evict_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_valid, mem_last, evict_ready, wb_done, mem_addr, mem_data} !==
          {1'b1, (b == 3), 1'b0, 1'b0, ea[b], ed[b]}) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b l=%b r=%b d=%b a=%h dat=%h want a=%h dat=%h",
                 b, mem_valid, mem_last, evict_ready, wb_done, mem_addr, mem_data, ea[b], ed[b]);
      end
      tick;
    end
    checks++;
    if ({wb_done, mem_valid, evict_ready} !== 3'b101) begin
      errors++; $display("FAIL single_done: got d/v/r=%b%b%b want 101", wb_done, mem_valid, evict_ready);
    end
    tick;
    checks++;
    if (wb_done !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got %b want 0", wb_done);
    end
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    // Expected beat index for each observed cycle. Beat 1 is stalled for 3 cycles.
    int exp_b [8];
    logic rdy [8];
    ea = '{23'h6AF168, 23'h6AF169, 23'h6AF16A, 23'h6AF16B};
    ed = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
    exp_b = '{0, 1, 1, 1, 1, 2, 3, 0};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    evict_tag = 13'h1ABC; evict_set = 8'h5A;
    evict_data = {ed[3], ed[2], ed[1], ed[0]};
    evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    evict_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = rdy[c];
      checks++;
      if ({mem_valid, mem_last, mem_addr, mem_data} !==
          {1'b1, (exp_b[c] == 3), ea[exp_b[c]], ed[exp_b[c]]}) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b l=%b a=%h dat=%h want a=%h dat=%h",
                 c, mem_valid, mem_last, mem_addr, mem_data, ea[exp_b[c]], ed[exp_b[c]]);
      end
      tick;
    end
    mem_ready = 1'b1;
    checks++;
    if ({wb_done, mem_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_done: got d/v=%b%b want 10", wb_done, mem_valid);
    end
    tick;
  endtask

  task automatic test_isolation;
    logic [AW-1:0] ea [4];
    logic [AW-1:0] eb [4];
    ea = '{23'h048CD0, 23'h048CD1, 23'h048CD2, 23'h048CD3};
    eb = '{23'h3FB72C, 23'h3FB72D, 23'h3FB72E, 23'h3FB72F};
    evict_tag = 13'h0123; evict_set = 8'h34;
    evict_data = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({evict_ready, mem_valid, mem_addr, mem_data} !==
          {1'b0, 1'b1, ea[b], {4{4'hB, 4'(b)}}}) begin
        errors++;
        $display("FAIL iso_a_beat%0d: got r=%b v=%b a=%h dat=%h want r=0 a=%h",
                 b, evict_ready, mem_valid, mem_addr, mem_data, ea[b]);
      end
      if (b < 3) begin
        evict_tag = evict_tag + 13'h0111; evict_set = evict_set ^ 8'hFF;
        evict_data = ~evict_data;
      end else begin
        evict_tag = 13'h0FED; evict_set = 8'hCB;
        evict_data = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
      end
      tick;
    end
    checks++;
    if ({wb_done, evict_ready} !== 2'b11) begin
      errors++; $display("FAIL iso_second_accept: got d/r=%b%b want 11", wb_done, evict_ready);
    end
    tick;
    evict_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_valid, mem_last, mem_addr, mem_data} !==
          {1'b1, (b == 3), eb[b], {4{4'hC, 4'(b)}}}) begin
        errors++;
        $display("FAIL iso_b_beat%0d: got v=%b l=%b a=%h dat=%h want a=%h",
                 b, mem_valid, mem_last, mem_addr, mem_data, eb[b]);
      end
      tick;
    end
    tick;
  endtask

  task automatic test_reset_mid;
    evict_tag = 13'h1ABC; evict_set = 8'h5A;
    evict_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    evict_valid = 1'b0;
    tick; tick;
    checks++;
    if (mem_addr !== 23'h6AF16A) begin
      errors++; $display("FAIL rstmid_on_beat2: got a=%h want 6af16a", mem_addr);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({mem_valid, evict_ready, wb_done} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_abandon: got v/r/d=%b%b%b want 000", mem_valid, evict_ready, wb_done);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({evict_ready, wb_done} !== 2'b10) begin
      errors++; $display("FAIL rstmid_release: got r/d=%b%b want 10", evict_ready, wb_done);
    end
    evict_tag = 13'h0123; evict_set = 8'h34; evict_valid = 1'b1;
    tick;
    evict_valid = 1'b0;
    checks++;
    if ({mem_valid, wb_done, mem_addr, mem_data} !== {2'b10, 23'h048CD0, 32'h11111111}) begin
      errors++;
      $display("FAIL rstmid_restart: got v=%b d=%b a=%h dat=%h want v=1 d=0 a=048cd0 dat=11111111",
               mem_valid, wb_done, mem_addr, mem_data);
    end
    tick; tick; tick; tick;
    checks++;
    if (wb_done !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart_done: got %b want 1", wb_done);
    end
    tick;
  endtask

  task automatic test_extremes;
    logic [AW-1:0] ea [4];
    ea = '{23'h7FFFFC, 23'h7FFFFD, 23'h7FFFFE, 23'h7FFFFF};
    evict_tag = 13'h1FFF; evict_set = 8'hFF;
    evict_data = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
    evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    evict_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({mem_valid, mem_addr, mem_data} !== {1'b1, ea[b], 28'hDEAD000, 4'(b)}) begin
        errors++;
        $display("FAIL extreme_beat%0d: got v=%b a=%h dat=%h want a=%h",
                 b, mem_valid, mem_addr, mem_data, ea[b]);
      end
      tick;
    end
    tick;
  endtask

`ifdef CACHE_WB_DIRTY_MASK_EN
  task automatic test_dirty_mask;
    evict_tag = 13'h1ABC; evict_set = 8'h5A;
    evict_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    evict_dirty_mask = 4'b1010; evict_valid = 1'b1; mem_ready = 1'b1;
    tick;
    evict_valid = 1'b0;
    checks++;
    if ({mem_valid, mem_last, mem_addr, mem_data} !== {2'b10, 23'h6AF169, 32'h22222222}) begin
      errors++; $display("FAIL mask_beat_off1: got v=%b l=%b a=%h dat=%h want l=0 a=6af169",
                         mem_valid, mem_last, mem_addr, mem_data);
    end
    tick;
    checks++;
    if ({mem_valid, mem_last, mem_addr, mem_data} !== {2'b11, 23'h6AF16B, 32'h44444444}) begin
      errors++; $display("FAIL mask_beat_off3: got v=%b l=%b a=%h dat=%h want l=1 a=6af16b",
                         mem_valid, mem_last, mem_addr, mem_data);
    end
    tick;
    checks++;
    if ({wb_done, mem_valid} !== 2'b10) begin
      errors++; $display("FAIL mask_done: got d/v=%b%b want 10", wb_done, mem_valid);
    end
    tick;
    evict_dirty_mask = 4'b0000; evict_valid = 1'b1;
    tick;
    evict_valid = 1'b0;
    checks++;
    if ({wb_done, mem_valid, evict_ready} !== 3'b101) begin
      errors++; $display("FAIL mask_zero: got d/v/r=%b%b%b want 101", wb_done, mem_valid, evict_ready);
    end
    evict_dirty_mask = '1;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_isolation;
    test_reset_mid;
    test_extremes;
`ifdef CACHE_WB_DIRTY_MASK_EN
    test_dirty_mask;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
